clock_divider_prog: RTL



---
 rtl/clock_divider_prog_if.sv | 31 +++
 rtl/clock_divider_prog.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/clock_divider_prog_if.sv
// Config reload channel for clock_divider_prog: target channel, divisor and mode.
// Single-beat valid/ready transfer; no internal storage or latency.
// Backpressure: the slave drops cfg_ready while the addressed channel still holds an unapplied config.
interface clock_divider_prog_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 2
);
  localparam int unsigned CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic              cfg_valid;
  logic              cfg_ready;
  logic [CHAN_W-1:0] cfg_chan;
  logic [WIDTH-1:0]  cfg_div;
  logic              cfg_mode;

  modport master (
    output cfg_valid,
    output cfg_chan,
    output cfg_div,
    output cfg_mode,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_chan,
    input  cfg_div,
    input  cfg_mode,
    output cfg_ready
  );
endinterface

// File: rtl/clock_divider_prog.sv
// Multi-channel programmable divider: per-channel one-cycle tick and square/pulse clk_out.
// Latency: tick and clk_out are registered; a new config lands at the next period boundary (or next edge when idle).
// Backpressure: cfg_ready is low for a channel from config acceptance until that config has been applied.
module clock_divider_prog #(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      CHANNELS    = 2,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(250_000)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  clock_divider_prog_if.slave cfg,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] clk_out
);
  localparam int unsigned CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  // Active divisor/mode and the counter walking through the current period
  logic [WIDTH-1:0]    cnt_q     [CHANNELS];
  logic [WIDTH-1:0]    cnt_d     [CHANNELS];
  logic [WIDTH-1:0]    div_q     [CHANNELS];
  logic [WIDTH-1:0]    div_d     [CHANNELS];
  logic [CHANNELS-1:0] mode_q, mode_d;

  // Shadow config waiting for a safe point to become active
  logic [WIDTH-1:0]    shd_div_q [CHANNELS];
  logic [WIDTH-1:0]    shd_div_d [CHANNELS];
  logic [CHANNELS-1:0] shd_mode_q, shd_mode_d;
  logic [CHANNELS-1:0] pend_q, pend_d;

  logic [CHANNELS-1:0] tick_q, tick_d;
  logic [CHANNELS-1:0] clk_out_q, clk_out_d;

  logic [CHANNELS-1:0] tc;
  logic [CHANNELS-1:0] xfer;

  // Terminal count compares in WIDTH bits; only meaningful while div_act >= 1
  for (genvar g = 0; g < CHANNELS; g++) begin : g_tc
    assign tc[g] = (cnt_q[g] == (div_q[g] - WIDTH'(1)));
  end

  // Ready mirrors the addressed channel's pending flag; out-of-range targets always accept
  always_comb begin
    cfg.cfg_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg.cfg_chan == CHAN_W'(i)) begin
        cfg.cfg_ready = ~pend_q[i];
      end
    end
  end

  // One-hot accept strobe; an out-of-range target matches no channel and is dropped
  always_comb begin
    xfer = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg.cfg_valid && cfg.cfg_ready && (cfg.cfg_chan == CHAN_W'(i))) begin
        xfer[i] = 1'b1;
      end
    end
  end

  // Per-channel counting, output generation and config apply
  always_comb begin
    cnt_d      = cnt_q;
    div_d      = div_q;
    mode_d     = mode_q;
    shd_div_d  = shd_div_q;
    shd_mode_d = shd_mode_q;
    pend_d     = pend_q;
    tick_d     = '0;
    clk_out_d  = clk_out_q;

    for (int i = 0; i < CHANNELS; i++) begin
      if (pend_q[i] && (!en[i] || (div_q[i] == '0))) begin
        // Nothing is running, so the new config can start from a clean slate right away
        div_d[i]     = shd_div_q[i];
        mode_d[i]    = shd_mode_q[i];
        cnt_d[i]     = '0;
        clk_out_d[i] = 1'b0;
        pend_d[i]    = 1'b0;
      end else if (div_q[i] == '0) begin
        // Halted channel parks with everything low
        cnt_d[i]     = '0;
        clk_out_d[i] = 1'b0;
      end else if (en[i]) begin
        if (tc[i]) begin
          cnt_d[i]  = '0;
          tick_d[i] = 1'b1;
          if (pend_q[i]) begin
            // Old period just completed; switch over here so clk_out never sees a runt
            div_d[i]     = shd_div_q[i];
            mode_d[i]    = shd_mode_q[i];
            pend_d[i]    = 1'b0;
            clk_out_d[i] = shd_mode_q[i] ? 1'b1 : ~clk_out_q[i];
          end else begin
            clk_out_d[i] = mode_q[i] ? 1'b1 : ~clk_out_q[i];
          end
        end else begin
          cnt_d[i] = cnt_q[i] + WIDTH'(1);
          if (mode_q[i]) begin
            clk_out_d[i] = 1'b0;
          end
        end
      end else begin
        // Paused: counter and square wave freeze; pulse output tracks the (low) tick
        if (mode_q[i]) begin
          clk_out_d[i] = 1'b0;
        end
      end

      // Accept only happens with pend_q low, so it never collides with an apply above
      if (xfer[i]) begin
        shd_div_d[i]  = cfg.cfg_div;
        shd_mode_d[i] = cfg.cfg_mode;
        pend_d[i]     = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]     <= '0;
        div_q[i]     <= DEFAULT_DIV;
        shd_div_q[i] <= '0;
      end
      mode_q     <= '0;
      shd_mode_q <= '0;
      pend_q     <= '0;
      tick_q     <= '0;
      clk_out_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      shd_div_q  <= shd_div_d;
      mode_q     <= mode_d;
      shd_mode_q <= shd_mode_d;
      pend_q     <= pend_d;
      tick_q     <= tick_d;
      clk_out_q  <= clk_out_d;
    end
  end

  assign tick    = tick_q;
  assign clk_out = clk_out_q;

endmodule
